// File: rtl/control_decoder.sv
// Registered 3-to-8 one-hot select for the SRAM control path, gated by enable.
// Latency 1 clock; no backpressure, a new decode is loaded on every rising edge.
module control_decoder #(
    parameter int ADDR_WIDTH = 3,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  enable,
    output logic [OUT_WIDTH-1:0]  out
);

    logic [OUT_WIDTH-1:0] decode;

    // At most one bit is ever set, so the registered output stays one-hot or zero.
    always_comb begin
        decode = '0;
        if (enable) begin
            decode[addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= decode;
        end
    end

endmodule

// File: tb/tb_control_decoder.sv
// Directed-vector bench for control_decoder with hand-computed expected values.
module tb_control_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] addr;
    logic       enable;
    logic [7:0] out;

    int chk_cnt;
    int pass_cnt;

    logic [7:0] exp_tbl [8];

    control_decoder #(
        .ADDR_WIDTH(3),
        .OUT_WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .enable(enable),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_onehot(input string tag);
        check(tag, {7'b0, ($countones(out) <= 1)}, 8'h01);
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        exp_tbl  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst    = 1'b1;
        enable = 1'b1;
        addr   = 3'd5;
        #2;

        // Reset has priority over an enabled decode.
        tick();
        check("reset_edge1", out, 8'h00);
        tick();
        check("reset_edge2", out, 8'h00);
        rst = 1'b0;
        tick();
        check("reset_release", out, 8'h20);

        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            tick();
            check($sformatf("decode_addr%0d", i), out, exp_tbl[i]);
            check_onehot($sformatf("onehot_addr%0d", i));
        end

        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            tick();
            check($sformatf("gated_addr%0d", i), out, 8'h00);
        end
        enable = 1'b1;
        addr   = 3'd3;
        tick();
        check("enable_on", out, 8'h08);
        enable = 1'b0;
        tick();
        check("enable_off", out, 8'h00);

        // Back-to-back changes never pass through an all-zero cycle.
        enable = 1'b1;
        addr   = 3'd0;
        tick();
        check("b2b_0", out, 8'h01);
        addr = 3'd7;
        tick();
        check("b2b_7", out, 8'h80);
        addr = 3'd0;
        tick();
        check("b2b_0_again", out, 8'h01);

        addr = 3'd6;
        tick();
        check("mid_pre_reset", out, 8'h40);
        rst = 1'b1;
        tick();
        check("mid_reset", out, 8'h00);
        rst = 1'b0;
        tick();
        check("mid_post_reset", out, 8'h40);

        // Input changes between edges must not reach the output until the next edge.
        addr = 3'd2;
        #2;
        check("hold_addr_change", out, 8'h40);
        tick();
        check("load_addr_change", out, 8'h04);
        enable = 1'b0;
        #2;
        check("hold_enable_drop", out, 8'h04);
        tick();
        check("load_enable_drop", out, 8'h00);
        enable = 1'b1;
        addr   = 3'd1;
        rst    = 1'b1;
        #2;
        check("hold_rst_rise", out, 8'h00);
        tick();
        check("rst_with_enable", out, 8'h00);
        rst = 1'b0;
        tick();
        check("after_rst_addr1", out, 8'h02);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
